// File: rtl/keypad_scan_3x4.sv
// Column-scanning front end for a 3x4 key matrix: drives one column low at a time,
// samples the synchronised rows and publishes an active-low key image per frame.
// Optional ghost-frame suppression is compiled in with `define KEYPAD_GHOST_MASK_EN.
module keypad_scan_3x4 #(
    parameter int CLK_DIV = 1000,
    parameter int SETTLE  = 8
) (
    input  logic        clk,
    input  logic        aresetn,
    output logic [2:0]  o_col_n,
    input  logic [3:0]  i_row_n,
    output logic [11:0] o_button_n,
    output logic        o_sync_n
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] SETTLE_END = DIV_W'(SETTLE + 1);

    generate
        if (CLK_DIV < SETTLE + 4) begin : g_bad_params
            $error("keypad_scan_3x4: CLK_DIV must be at least SETTLE+4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD,
        S_PUBLISH
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [2:0]       col_n_q, col_n_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic [11:0]      shadow_q, shadow_d;
    logic [11:0]      button_q, button_d;
    logic             pub_q, pub_d;
    logic             sync_n_q;

    logic [11:0]      col_hit;
    logic [11:0]      row_bit;
    logic             frame_ghost;

    // Spread the sampled rows across the image so one column write touches bits r*3+col.
    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_img_map
            assign col_hit[gi] = (col_q == 2'(gi % 3));
            assign row_bit[gi] = row_sync_q[gi / 3];
        end
    endgenerate

`ifdef KEYPAD_GHOST_MASK_EN
    logic [11:0] pressed;
    logic        rect;

    assign pressed = ~shadow_q;

    // A rectangle of closed contacts makes a fourth, phantom closure indistinguishable.
    always_comb begin
        rect = 1'b0;
        for (int r1 = 0; r1 < 3; r1++) begin
            for (int r2 = r1 + 1; r2 < 4; r2++) begin
                if ($countones(pressed[r1*3 +: 3] & pressed[r2*3 +: 3]) >= 2) begin
                    rect = 1'b1;
                end
            end
        end
    end

    assign frame_ghost = ($countones(pressed) >= 3) && rect;
`else
    assign frame_ghost = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        col_d    = col_q;
        col_n_d  = col_n_q;
        shadow_d = shadow_q;
        button_d = button_q;
        pub_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                col_d   = 2'd0;
                col_n_d = 3'b110;
                div_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                div_d = div_q + 1'b1;
                if (div_q == SETTLE_END) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                div_d    = div_q + 1'b1;
                shadow_d = (shadow_q & ~col_hit) | (row_bit & col_hit);
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    if (col_q == 2'd2) begin
                        state_d = S_PUBLISH;
                    end else begin
                        col_d   = col_q + 1'b1;
                        col_n_d = {col_n_q[1:0], 1'b1};
                        div_d   = '0;
                        state_d = S_SETTLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_PUBLISH: begin
                if (!frame_ghost) begin
                    button_d = shadow_q;
                    pub_d    = 1'b1;
                end
                col_d   = 2'd0;
                col_n_d = 3'b110;
                div_d   = '0;
                state_d = S_SETTLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            col_q      <= 2'd0;
            col_n_q    <= 3'b111;
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            shadow_q   <= 12'hFFF;
            button_q   <= 12'hFFF;
            pub_q      <= 1'b0;
            sync_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            col_q      <= col_d;
            col_n_q    <= col_n_d;
            row_meta_q <= i_row_n;
            row_sync_q <= row_meta_q;
            shadow_q   <= shadow_d;
            button_q   <= button_d;
            pub_q      <= pub_d;
            // Strobe trails the image update by one cycle so the image is already settled.
            sync_n_q   <= ~pub_q;
        end
    end

    assign o_col_n    = col_n_q;
    assign o_button_n = button_q;
    assign o_sync_n   = sync_n_q;

endmodule

// File: doc/keypad_scan_3x4.md
Name: keypad_scan_3x4

Overview:
Column-scanning front end for the 3x4 button matrix; sits directly upstream of the per-key debounce filters.
- Drives one of 3 column lines low at a time.
- Samples the 4 pulled-up row lines through a synchroniser.
- Publishes a 12-bit active-low key image, `o_button_n`.
- Emits a one-cycle active-low poll strobe, `o_sync_n`. Each filter advances its press counter only on this strobe.

Parameters:
- CLK_DIV, 1000: clk cycles per column slot. Legal range is CLK_DIV >= SETTLE+4; enforce with a static assertion.
- SETTLE, 8: cycles after a column change before the row value is trusted.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous reset, active-low
- o_col_n  out  3  column drive, one-hot active-low
- i_row_n  in  4  raw row inputs, asynchronous, active-low (pulled up)
- o_button_n  out  12  key image, active-low; bit index = row*3 + col
- o_sync_n  out  1  frame-complete strobe, active-low, 1 clk wide

Behaviour:
- Reset state (asynchronous, immediate, also mid-scan):
  - o_col_n=3'b111, o_button_n=12'hFFF, o_sync_n=1.
  - Row synchroniser flops = 4'hF, shadow register = 12'hFFF.
  - div counter=0, column index=0, FSM=S_IDLE.
- Row synchroniser: 2 flops on i_row_n; all sampling uses the second stage.
- FSM states: S_IDLE -> S_SETTLE -> S_SAMPLE -> S_HOLD -> (S_SETTLE or S_PUBLISH).
  - S_IDLE: lasts 1 cycle after reset release. Sets o_col_n=3'b110, col=0, div=0.
  - S_SETTLE: div increments each cycle. At div==SETTLE+1 go to S_SAMPLE.
  - S_SAMPLE: 1 cycle. Captures sync_row[r] into shadow[r*3+col] for r=0..3. Go to S_HOLD.
  - S_HOLD: div increments until div==CLK_DIV-1. Then:
    - col<2: col++, div=0, o_col_n advances (110 -> 101 -> 011), go to S_SETTLE.
    - col==2: go to S_PUBLISH.
  - S_PUBLISH: 1 cycle.
    - o_button_n <= shadow.
    - col=0, o_col_n=3'b110, div=0, go to S_SETTLE.
    - o_sync_n goes low on the following clk edge for exactly 1 cycle.
    - o_button_n is therefore stable for at least 1 cycle before and during the strobe.
- Frame period: 3*CLK_DIV + 1 cycles; o_sync_n pulses once per frame.
- o_button_n changes only in S_PUBLISH, never while o_sync_n is low.
- Exactly one column is low at any time outside reset/S_IDLE, with no overlap at transitions (registered one-hot).
- Shadow bits are overwritten every frame, so no stale press survives.
- A row change during S_SETTLE/S_HOLD is ignored. Only the S_SAMPLE value counts.
- Multiple keys in one frame are published as-is; see the optional feature.

Optional Feature:
- Macro: KEYPAD_GHOST_MASK_EN
- Enabled:
  - In S_PUBLISH, if the shadow shows >=3 pressed keys and any two rows share two pressed columns (a rectangle), the frame is ghost.
  - A ghost frame leaves o_button_n unchanged and suppresses that frame's o_sync_n pulse; the downstream filters hold their state.
  - The next clean frame publishes normally.
- Disabled: every frame is published and strobed, ghosts included.

Test Plan (CLK_DIV=16, SETTLE=4; cycle 0 = first edge after aresetn release):
- Idle:
  - Stimulus: all rows high, run 200 cycles.
  - Required: o_col_n sequences 110/101/011 with 16-cycle slots; o_sync_n low 1 cycle every 49 cycles; o_button_n stays 12'hFFF.
- Single key:
  - Stimulus: hold the row1/col2 contact closed (i_row_n[1] low whenever o_col_n[2]==0).
  - Required: at the first publish, o_button_n = 12'hFFF with bit 5 = 0; every other bit stays 1; image repeats each frame.
- Settle window:
  - Stimulus: glitch i_row_n[0] low only during div 0..SETTLE-1 of col0.
  - Required: bit 0 remains 1.
- Release:
  - Stimulus: press key 11, then release.
  - Required: bit 11 returns to 1 at the first publish whose col2 sample follows the release.
- Reset mid-scan:
  - Stimulus: assert aresetn during col1 S_HOLD.
  - Required: immediately o_col_n=111, o_button_n=FFF, o_sync_n=1; after release the scan restarts at col0 and the first strobe occurs 49 cycles later.
- Ghost (macro on):
  - Stimulus: keys 0, 1, 3 closed, producing phantom key 4.
  - Required: no o_sync_n pulse and o_button_n unchanged. With the macro off, o_button_n shows bits 0, 1, 3, 4 low and o_sync_n pulses.
